// File: rtl/freq_scheduler.sv
// freq_scheduler: queues MIDI key events, allocates two voices and commits ids on vsync rise; FREQ_SCHED_SORT_EN orders the outputs.
// Latency: key_valid to shadow update 3 cycles with the queue empty; outputs follow at the next vsync commit.
// Backpressure: none upstream; an event arriving with the queue full is dropped and sets sticky overflow.
module freq_scheduler #(
    parameter int BASE_KEY   = 48,
    parameter int FIFO_DEPTH = 4,
    parameter int LOG_DEPTH  = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic       key_on,
    input  logic [6:0] key_index,
    input  logic       vsync,
    input  logic       sw_override,
    input  logic [4:0] sw_freq_id,
    output logic [4:0] freq_id1,
    output logic [4:0] freq_id2,
    output logic       new_f,
    output logic [1:0] active,
    output logic       overflow
);
    typedef struct packed {
        logic       on;
        logic [6:0] key;
    } key_ev_t;

    typedef enum logic [1:0] {S_IDLE, S_POP, S_ALLOC} state_t;

    key_ev_t              fifo_mem [FIFO_DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   fifo_cnt;
    logic                 fifo_full;
    logic                 fifo_vld;
    logic                 push_vld;
    logic                 pop_rdy;

    state_t     state;
    key_ev_t    ev;
    logic [4:0] sid1;
    logic [4:0] sid2;
    logic [1:0] sact;
    logic       age;
    logic       pending;
    logic       vs_d;
    logic       ov_d;
    logic [4:0] sfid_d;

    // Depth is a power of two, so the count MSB alone means full.
    assign fifo_full = fifo_cnt[LOG_DEPTH];
    assign fifo_vld  = (fifo_cnt != '0);
    assign push_vld  = key_valid && !fifo_full;
    assign pop_rdy   = (state == S_POP) && fifo_vld;

    always_ff @(posedge clock) begin
        if (push_vld) begin
            fifo_mem[wr_ptr] <= {key_on, key_index};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (pop_rdy) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            case ({push_vld, pop_rdy})
                2'b10:   fifo_cnt <= fifo_cnt + (LOG_DEPTH+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (LOG_DEPTH+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (key_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Keys below BASE_KEY wrap to a large offset, so one upper-bits test covers both ends.
    logic [7:0] ev_off;
    logic       in_range;
    logic [4:0] fid;
    logic       held1;
    logic       held2;
    logic       use_v1;

    assign ev_off   = {1'b0, ev.key} - 8'(BASE_KEY);
    assign in_range = (ev_off[7:5] == 3'd0);
    assign fid      = ev_off[4:0];
    assign held1    = sact[0] && (sid1 == fid);
    assign held2    = sact[1] && (sid2 == fid);
    // age = 0 marks v1 as the older voice, so it is the one stolen.
    assign use_v1   = !sact[0] || (sact[1] && !age);

    logic [4:0] n_sid1;
    logic [4:0] n_sid2;
    logic [1:0] n_sact;
    logic       n_age;

    always_comb begin
        n_sid1 = sid1;
        n_sid2 = sid2;
        n_sact = sact;
        n_age  = age;
        if (ev.on) begin
            if (!(held1 || held2)) begin
                if (use_v1) begin
                    n_sid1    = fid;
                    n_sact[0] = 1'b1;
                    n_age     = 1'b1;
                end else begin
                    n_sid2    = fid;
                    n_sact[1] = 1'b1;
                    n_age     = 1'b0;
                end
            end
        end else begin
            if (held1) n_sact[0] = 1'b0;
            if (held2) n_sact[1] = 1'b0;
        end
    end

    logic [4:0] c_id1;
    logic [4:0] c_id2;
    logic [1:0] c_act;

    always_comb begin
        c_id1 = sid1;
        c_id2 = sid2;
        c_act = sact;
        if (sw_override) begin
            c_id1 = sw_freq_id;
            c_id2 = sw_freq_id;
            c_act = 2'b11;
        end
`ifdef FREQ_SCHED_SORT_EN
        else if ((&sact) && (sid1 > sid2)) begin
            c_id1 = sid2;
            c_id2 = sid1;
            c_act = {sact[0], sact[1]};
        end
`endif
    end

    logic vs_rise;
    logic ov_chg;
    logic commit;

    assign vs_rise = vsync && !vs_d;
    assign ov_chg  = (sw_override != ov_d) || (sw_override && (sw_freq_id != sfid_d));
    assign commit  = vs_rise && pending;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ev       <= '0;
            sid1     <= '0;
            sid2     <= '0;
            sact     <= '0;
            age      <= 1'b0;
            pending  <= 1'b0;
            vs_d     <= 1'b0;
            ov_d     <= 1'b0;
            sfid_d   <= '0;
            freq_id1 <= '0;
            freq_id2 <= '0;
            active   <= '0;
            new_f    <= 1'b0;
        end else begin
            vs_d   <= vsync;
            ov_d   <= sw_override;
            sfid_d <= sw_freq_id;
            new_f  <= 1'b0;
            if (commit) begin
                freq_id1 <= c_id1;
                freq_id2 <= c_id2;
                active   <= c_act;
                new_f    <= 1'b1;
                pending  <= 1'b0;
            end
            // Later assignments win: a change landing on a commit cycle waits for the next frame.
            if (ov_chg) begin
                pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (fifo_vld) state <= S_POP;
                end
                S_POP: begin
                    ev    <= fifo_mem[rd_ptr];
                    state <= S_ALLOC;
                end
                S_ALLOC: begin
                    if (in_range) begin
                        sid1    <= n_sid1;
                        sid2    <= n_sid2;
                        sact    <= n_sact;
                        age     <= n_age;
                        pending <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_scheduler.sv
// Directed bench for freq_scheduler: voice allocation, stealing, vsync commit, overflow and override.
module tb_freq_scheduler;
    logic       clock;
    logic       reset_n;
    logic       key_valid;
    logic       key_on;
    logic [6:0] key_index;
    logic       vsync;
    logic       sw_override;
    logic [4:0] sw_freq_id;
    logic [4:0] freq_id1;
    logic [4:0] freq_id2;
    logic       new_f;
    logic [1:0] active;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    freq_scheduler dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key_on     (key_on),
        .key_index  (key_index),
        .vsync      (vsync),
        .sw_override(sw_override),
        .sw_freq_id (sw_freq_id),
        .freq_id1   (freq_id1),
        .freq_id2   (freq_id2),
        .new_f      (new_f),
        .active     (active),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #8 clock = ~clock;

    task automatic press(input logic on, input logic [6:0] key);
        @(negedge clock);
        key_valid = 1'b1;
        key_on    = on;
        key_index = key;
        @(negedge clock);
        key_valid = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic do_vsync(output int pulses);
        pulses = 0;
        @(negedge clock);
        vsync = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (new_f) pulses++;
        end
        vsync = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (new_f) pulses++;
        end
    endtask

    task automatic test_reset();
        int p;
        int q;
        reset_n = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if ({freq_id1, freq_id2, active, new_f, overflow} !== 14'd0) begin
            failures++;
            $display("FAIL reset_hold outs=%h exp=0", {freq_id1, freq_id2, active, new_f, overflow});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({freq_id1, freq_id2, active, new_f, overflow} !== 14'd0) begin
            failures++;
            $display("FAIL reset_release outs=%h exp=0", {freq_id1, freq_id2, active, new_f, overflow});
        end
        do_vsync(p);
        do_vsync(q);
        checks++;
        if (p + q !== 0) begin
            failures++;
            $display("FAIL reset_no_new_f pulses=%0d exp=0", p + q);
        end
    endtask

    task automatic test_single_note();
        int p;
        press(1'b1, 7'd50);
        do_vsync(p);
        checks++;
        if ({freq_id1, freq_id2, active} !== {5'd2, 5'd0, 2'b01}) begin
            failures++;
            $display("FAIL single_ids got=%0d/%0d/%b exp=2/0/01", freq_id1, freq_id2, active);
        end
        checks++;
        if (p !== 1) begin
            failures++;
            $display("FAIL single_pulse pulses=%0d exp=1", p);
        end
        do_vsync(p);
        checks++;
        if (p !== 0) begin
            failures++;
            $display("FAIL single_repeat pulses=%0d exp=0", p);
        end
    endtask

    task automatic test_two_notes_steal();
        int p;
        logic [4:0] e1, e2;
        press(1'b0, 7'd50);
        press(1'b1, 7'd52);
        press(1'b1, 7'd55);
        do_vsync(p);
        checks++;
        if ({freq_id1, freq_id2, active} !== {5'd4, 5'd7, 2'b11} || p !== 1) begin
            failures++;
            $display("FAIL two_notes got=%0d/%0d/%b pulses=%0d exp=4/7/11 pulses=1", freq_id1, freq_id2, active, p);
        end
        press(1'b1, 7'd60);
        do_vsync(p);
`ifdef FREQ_SCHED_SORT_EN
        e1 = 5'd7;  e2 = 5'd12;
`else
        e1 = 5'd12; e2 = 5'd7;
`endif
        checks++;
        if ({freq_id1, freq_id2} !== {e1, e2}) begin
            failures++;
            $display("FAIL steal_ids got=%0d/%0d exp=%0d/%0d", freq_id1, freq_id2, e1, e2);
        end
        checks++;
        if (active !== 2'b11) begin
            failures++;
            $display("FAIL steal_active got=%b exp=11", active);
        end
        checks++;
        if (p !== 1) begin
            failures++;
            $display("FAIL steal_pulse pulses=%0d exp=1", p);
        end
    endtask

    task automatic test_release_range();
        int p;
        press(1'b0, 7'd55);
        press(1'b1, 7'd90);
        do_vsync(p);
        checks++;
        if ({freq_id1, freq_id2, active} !== {5'd12, 5'd7, 2'b01}) begin
            failures++;
            $display("FAIL release_ids got=%0d/%0d/%b exp=12/7/01", freq_id1, freq_id2, active);
        end
        checks++;
        if (p !== 1) begin
            failures++;
            $display("FAIL release_pulse pulses=%0d exp=1", p);
        end
    endtask

    // First key is out of range; the sixth arrives with the queue full and is dropped.
    task automatic test_overflow();
        int p;
        logic [6:0] keys [6];
        logic [4:0] e1, e2;
        keys = '{7'd20, 7'd49, 7'd51, 7'd53, 7'd56, 7'd58};
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_pre got=%b exp=0", overflow);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            key_valid = 1'b1;
            key_on    = 1'b1;
            key_index = keys[i];
        end
        @(negedge clock);
        key_valid = 1'b0;
        repeat (30) @(negedge clock);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag got=%b exp=1", overflow);
        end
        do_vsync(p);
`ifdef FREQ_SCHED_SORT_EN
        e1 = 5'd5; e2 = 5'd8;
`else
        e1 = 5'd8; e2 = 5'd5;
`endif
        checks++;
        if ({freq_id1, freq_id2, active} !== {e1, e2, 2'b11} || p !== 1) begin
            failures++;
            $display("FAIL overflow_ids got=%0d/%0d/%b pulses=%0d exp=%0d/%0d/11 pulses=1", freq_id1, freq_id2, active, p, e1, e2);
        end
    endtask

    task automatic test_override();
        int p;
        @(negedge clock);
        sw_override = 1'b1;
        sw_freq_id  = 5'd9;
        repeat (2) @(negedge clock);
        do_vsync(p);
        checks++;
        if ({freq_id1, freq_id2, active} !== {5'd9, 5'd9, 2'b11} || p !== 1) begin
            failures++;
            $display("FAIL override_on got=%0d/%0d/%b pulses=%0d exp=9/9/11 pulses=1", freq_id1, freq_id2, active, p);
        end
        @(negedge clock);
        sw_freq_id = 5'd17;
        do_vsync(p);
        checks++;
        if ({freq_id1, freq_id2, active} !== {5'd17, 5'd17, 2'b11} || p !== 1) begin
            failures++;
            $display("FAIL override_id_change got=%0d/%0d/%b pulses=%0d exp=17/17/11 pulses=1", freq_id1, freq_id2, active, p);
        end
        do_vsync(p);
        checks++;
        if (p !== 0) begin
            failures++;
            $display("FAIL override_idle pulses=%0d exp=0", p);
        end
        press(1'b0, 7'd56);
        do_vsync(p);
        checks++;
        if ({freq_id1, freq_id2, active} !== {5'd17, 5'd17, 2'b11} || p !== 1) begin
            failures++;
            $display("FAIL override_hold got=%0d/%0d/%b pulses=%0d exp=17/17/11 pulses=1", freq_id1, freq_id2, active, p);
        end
        @(negedge clock);
        sw_override = 1'b0;
        do_vsync(p);
        checks++;
        if ({freq_id1, freq_id2, active} !== {5'd8, 5'd5, 2'b10}) begin
            failures++;
            $display("FAIL override_restore got=%0d/%0d/%b exp=8/5/10", freq_id1, freq_id2, active);
        end
        checks++;
        if (p !== 1) begin
            failures++;
            $display("FAIL override_restore_pulse pulses=%0d exp=1", p);
        end
    endtask

    // ALLOC for key 57 lands on the vsync commit edge: the old shadow commits, the new one waits a frame.
    task automatic test_back_to_back();
        int p;
        logic [4:0] a1, a2, b1, b2;
        press(1'b1, 7'd59);
`ifdef FREQ_SCHED_SORT_EN
        a1 = 5'd5;  a2 = 5'd11; b1 = 5'd9;  b2 = 5'd11;
`else
        a1 = 5'd11; a2 = 5'd5;  b1 = 5'd11; b2 = 5'd9;
`endif
        @(negedge clock);
        key_valid = 1'b1;
        key_on    = 1'b1;
        key_index = 7'd57;
        @(negedge clock);
        key_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        vsync = 1'b1;
        @(negedge clock);
        checks++;
        if (new_f !== 1'b1) begin
            failures++;
            $display("FAIL b2b_commit_pulse got=%b exp=1", new_f);
        end
        checks++;
        if ({freq_id1, freq_id2, active} !== {a1, a2, 2'b11}) begin
            failures++;
            $display("FAIL b2b_pre_alloc got=%0d/%0d/%b exp=%0d/%0d/11", freq_id1, freq_id2, active, a1, a2);
        end
        @(negedge clock);
        vsync = 1'b0;
        repeat (3) @(negedge clock);
        do_vsync(p);
        checks++;
        if ({freq_id1, freq_id2, active} !== {b1, b2, 2'b11}) begin
            failures++;
            $display("FAIL b2b_next_frame got=%0d/%0d/%b exp=%0d/%0d/11", freq_id1, freq_id2, active, b1, b2);
        end
        checks++;
        if (p !== 1) begin
            failures++;
            $display("FAIL b2b_next_pulse pulses=%0d exp=1", p);
        end
        do_vsync(p);
        checks++;
        if (p !== 0) begin
            failures++;
            $display("FAIL b2b_quiet pulses=%0d exp=0", p);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky got=%b exp=1", overflow);
        end
        @(negedge clock);
        key_valid = 1'b1;
        key_on    = 1'b1;
        key_index = 7'd62;
        @(negedge clock);
        key_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({freq_id1, freq_id2, active, new_f, overflow} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid outs=%h exp=0", {freq_id1, freq_id2, active, new_f, overflow});
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        do_vsync(p);
        checks++;
        if (p !== 0 || {freq_id1, freq_id2, active} !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid_flush pulses=%0d outs=%h exp pulses=0 outs=0", p, {freq_id1, freq_id2, active});
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        key_valid   = 1'b0;
        key_on      = 1'b0;
        key_index   = '0;
        vsync       = 1'b0;
        sw_override = 1'b0;
        sw_freq_id  = '0;
        test_reset();
        test_single_note();
        test_two_notes_steal();
        test_release_range();
        test_overflow();
        test_override();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
